// File: rtl/counter_pwm.sv
// counter_pwm: registered PWM driven by an external free-running counter, with a shadowed duty that is applied only at period start.
// Optional COUNTER_PWM_PERIOD_CNT_EN adds a saturating 16-bit period counter output.
`default_nettype none

module counter_pwm #(
  parameter int               CNT_WIDTH  = 3,
  parameter logic [CNT_WIDTH:0] DUTY_RESET = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CNT_WIDTH-1:0] cnt_in,
  input  logic                 en,
  input  logic [CNT_WIDTH:0]   duty_in,
  input  logic                 duty_valid,
  output logic                 duty_ready,
  output logic                 pwm_out,
`ifdef COUNTER_PWM_PERIOD_CNT_EN
  output logic [15:0]          period_cnt,
`endif
  output logic                 period_done
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CNT_WIDTH:0] pending_q, pending_d;
  logic [CNT_WIDTH:0] active_q, active_d;
  logic               pwm_q, pwm_d;
  logic               done_q, done_d;
  logic               period_start;
  logic               transfer;
  logic               accept;
  logic [CNT_WIDTH:0] duty_eff;

  assign period_start = (cnt_in == '0);
  assign transfer     = (state_q == S_FULL) && period_start;
  assign accept       = duty_valid && duty_ready;

  // The transferred value is used by the compare in the same cycle, so a new duty covers a full period.
  assign duty_eff = transfer ? pending_q : active_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (duty_valid) state_d = S_FULL;
      S_FULL:  if (period_start) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    duty_ready = (state_q == S_EMPTY);
  end

  always_comb begin
    pending_d = accept ? duty_in : pending_q;
    active_d  = transfer ? pending_q : active_q;
    pwm_d     = en && ({1'b0, cnt_in} < duty_eff);
    done_d    = &cnt_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      active_q  <= DUTY_RESET;
      pwm_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      active_q  <= active_d;
      pwm_q     <= pwm_d;
      done_q    <= done_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = done_q;

`ifdef COUNTER_PWM_PERIOD_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;

  always_comb begin
    pcnt_d = pcnt_q;
    if (done_d && (pcnt_q != 16'hFFFF)) pcnt_d = pcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= 16'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign period_cnt = pcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_pwm.sv
// Self-checking bench for counter_pwm: directed test-plan scenarios plus randomized traffic against a behavioural model.
`default_nettype none

module tb_counter_pwm;

  logic       clk;
  logic       reset;
  logic [2:0] cnt_in;
  logic       en;
  logic [3:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic       period_done;
`ifdef COUNTER_PWM_PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  counter_pwm #(.CNT_WIDTH(3), .DUTY_RESET(4'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .cnt_in      (cnt_in),
    .en          (en),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_out     (pwm_out),
`ifdef COUNTER_PWM_PERIOD_CNT_EN
    .period_cnt  (period_cnt),
`endif
    .period_done (period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model: the counter value, the shadow slot and the active duty as plain integers.
  int  cnt      = 0;
  bit  hold_cnt = 0;
  bit  m_full   = 0;
  int  m_pend   = 0;
  int  m_act    = 0;
  int  m_pcnt   = 0;
  bit  e_pwm    = 0;
  bit  e_pd     = 0;
  int  hi_acc   = 0;
  int  hi       = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at posedge+1: drives one cycle of inputs, advances the model, then checks outputs after the edge.
  task automatic step(input bit e, input bit v, input logic [3:0] d);
    int eff;
    en         = e;
    duty_valid = v;
    duty_in    = d;
    cnt_in     = 3'(cnt);
    eff   = (m_full && cnt == 0) ? m_pend : m_act;
    e_pwm = e && (cnt < eff);
    e_pd  = (cnt == 7);
    if (e_pd && m_pcnt < 65535) m_pcnt++;
    if (m_full && cnt == 0) begin
      m_act  = m_pend;
      m_full = 0;
    end else if (!m_full && v) begin
      m_pend = int'(d);
      m_full = 1;
    end
    @(posedge clk);
    #1;
    if (!hold_cnt) cnt = (cnt + 1) % 8;
    check("pwm_out", 32'(pwm_out), 32'(e_pwm));
    check("period_done", 32'(period_done), 32'(e_pd));
    check("duty_ready", 32'(duty_ready), 32'(!m_full));
`ifdef COUNTER_PWM_PERIOD_CNT_EN
    check("period_cnt", 32'(period_cnt), 32'(m_pcnt));
`endif
    hi_acc += int'(pwm_out);
  endtask

  // One full period starting at cnt 0; offers duty d at counter value wk (wk<0: no write).
  task automatic run_period(input int wk, input logic [3:0] d, output int highs);
    hi_acc = 0;
    for (int i = 0; i < 8; i++) step(1'b1, (i == wk), d);
    highs = hi_acc;
  endtask

  initial begin : main
    bit         src_busy;
    logic [3:0] src_d;
    bit         e;
    bit         acc;

    reset      = 1'b1;
    cnt_in     = '0;
    en         = 1'b0;
    duty_in    = '0;
    duty_valid = 1'b0;
    #3;
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_done", 32'(period_done), 32'd0);
    check("rst_ready", 32'(duty_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Default duty 0: no highs, period_done checked each cycle by the model.
    run_period(-1, 4'd0, hi); check("idle_hi0", 32'(hi), 32'd0);
    run_period(-1, 4'd0, hi); check("idle_hi1", 32'(hi), 32'd0);

    // Write 3 at cnt 5; takes effect next period.
    run_period(5, 4'd3, hi);  check("w3_same", 32'(hi), 32'd0);
    run_period(-1, 4'd0, hi); check("w3_next", 32'(hi), 32'd3);

    run_period(2, 4'd8, hi);  check("w8_same", 32'(hi), 32'd3);
    run_period(-1, 4'd0, hi); check("w8_next", 32'(hi), 32'd8);
    run_period(2, 4'd9, hi);  check("w9_same", 32'(hi), 32'd8);
    run_period(-1, 4'd0, hi); check("w9_next", 32'(hi), 32'd8);
    run_period(2, 4'd0, hi);  check("w0_same", 32'(hi), 32'd8);
    run_period(-1, 4'd0, hi); check("w0_next", 32'(hi), 32'd0);

    // Handshake exactly at cnt 0 while EMPTY waits a whole period.
    run_period(3, 4'd2, hi);
    run_period(-1, 4'd0, hi); check("w2_next", 32'(hi), 32'd2);
    run_period(0, 4'd5, hi);  check("w5_at0", 32'(hi), 32'd2);
    run_period(-1, 4'd0, hi); check("w5_next", 32'(hi), 32'd5);

    // Reset while FULL with pending 6 and pwm high.
    run_period(1, 4'd8, hi);
    run_period(-1, 4'd0, hi); check("pre_rst_hi", 32'(hi), 32'd8);
    for (int i = 0; i < 5; i++) step(1'b1, (i == 3), 4'd6);
    check("pre_rst_pwm", 32'(pwm_out), 32'd1);
    check("pre_rst_full", 32'(duty_ready), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pwm", 32'(pwm_out), 32'd0);
    check("arst_ready", 32'(duty_ready), 32'd1);
    check("arst_done", 32'(period_done), 32'd0);
    m_full = 0; m_act = 0; m_pend = 0; m_pcnt = 0; cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_period(-1, 4'd0, hi); check("post_rst_hi0", 32'(hi), 32'd0);
    run_period(-1, 4'd0, hi); check("post_rst_hi1", 32'(hi), 32'd0);
    for (int i = 0; i < 3; i++) run_period(-1, 4'd0, hi);
`ifdef COUNTER_PWM_PERIOD_CNT_EN
    check("pcnt_5", 32'(period_cnt), 32'd5);
`endif

    // Randomized traffic: source holds duty until accepted, en toggles, counter sometimes stalls at 0.
    src_busy = 0;
    src_d    = '0;
    for (int n = 0; n < 600; n++) begin
      hold_cnt = (cnt == 0) && ($urandom_range(0, 3) == 0);
      if (!src_busy && $urandom_range(0, 3) == 0) begin
        src_busy = 1;
        src_d    = 4'($urandom_range(0, 15));
      end
      e   = ($urandom_range(0, 7) != 0);
      acc = src_busy && !m_full;
      step(e, src_busy, src_d);
      if (acc) src_busy = 0;
    end
    hold_cnt = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule

`default_nettype wire
